dual_issue_queue: RTL and testbench
===================================

// Module: dual_issue_queue
// PURPOSE
//   Instruction buffer between dual_fetch and the dual-issue execute stage. Accepts up to two
//   fetched instructions per cycle into a circular queue, presents the two oldest entries
//   show-ahead, and dual-issues them only when the pair is free of intra-pair hazards.
//   Drives the fetch stall and absorbs flushes on branch redirect.
// PARAMETERS
//   DEPTH   8   queue entries; power of 2, >= 4
//   XLEN    32  pc/instruction width
// PORTS
//   clk          in   1          clock, all state on rising edge
//   rst          in   1          synchronous reset, active-high
//   flush        in   1          discard all entries (branch redirect)
//   in_valid_0   in   1          fetch slot 0 valid
//   in_valid_1   in   1          fetch slot 1 valid (program order after slot 0)
//   in_pc_0      in   XLEN       slot 0 pc
//   in_pc_1      in   XLEN       slot 1 pc
//   in_inst_0    in   XLEN       slot 0 instruction
//   in_inst_1    in   XLEN       slot 1 instruction
//   stall_fetch  out  1          queue cannot accept a full pair; fetch must hold
//   issue_ready  in   1          execute accepts the offered instructions this cycle
//   out_valid_0  out  1          oldest entry offered
//   out_valid_1  out  1          second-oldest entry offered as dual-issue partner
//   out_pc_0     out  XLEN       oldest entry pc
//   out_pc_1     out  XLEN       second entry pc
//   out_inst_0   out  XLEN       oldest entry instruction
//   out_inst_1   out  XLEN       second entry instruction
//   count        out  log2(DEPTH)+1  occupied entries
// BEHAVIOUR
//   - Reset (rst=1 at edge): head=tail=count=0. Resulting outputs: out_valid_0/1=0,
//     stall_fetch=0, out_pc_0/1=0, out_inst_0/1=32'h00000013 (NOP).
//   - Invalid out slot always shows pc=0, inst=NOP; valid slots show queue entry (combinational).
//   - stall_fetch = (count >= DEPTH-1), from registered count only; does not credit same-cycle issue.
//   - Enqueue when !stall_fetch && !flush: valid slots written at tail in order (slot 0 then 1);
//     in_valid_1 without in_valid_0 writes slot 1 alone. Inputs ignored while stall_fetch=1.
//   - Latency: entry written at edge N is offered from cycle after edge N; no bypass.
//   - out_valid_0 = (count >= 1).
//   - out_valid_1 = (count >= 2) && !pair_hazard(I0=head, I1=head+1):
//       writes_rd: opcode in {0110011,0010011,0000011,0110111,0010111,1101111,1100111}, rd!=0
//       reads_rs1: all except {0110111,0010111,1101111}; reads_rs2: {0110011,0100011,1100011}
//       RAW: I0 writes_rd and I1 reads rs1/rs2 == I0.rd
//       WAW: both writes_rd with equal rd
//       MEM: both opcodes in {0000011,0100011}
//       CTRL: I0 opcode in {1100011,1101111,1100111}
//   - Dequeue when issue_ready && !flush: pops out_valid_0 + out_valid_1 entries from head.
//   - count_next = count + enq - deq; simultaneous enq and deq in same cycle allowed.
//   - Pointers are log2(DEPTH) bits, wrap modulo DEPTH.
//   - flush: next edge head=tail=count=0; same-cycle enqueue and dequeue both ignored.
//   - rst wins over flush; rst mid-operation discards all entries.
// TESTING
//   1. Assert rst 2 cycles -> count=0, out_valid_0/1=0, stall_fetch=0, out_inst_0/1=32'h13.
//   2. Enqueue 00500093/00A00113 (pc 0/4), issue_ready=0 -> count=2, out_valid_0=1,
//      out_valid_1=1; then issue_ready=1 -> count=0 next cycle.
//   3. Enqueue 002081B3, 00308333 (RAW on x3) -> out_valid_1=0; drains one per cycle,
//      second entry is offered alone in slot 0 next cycle.
//   4. DEPTH=8, issue_ready=0, push 4 pairs -> stall_fetch=0 at count=6, 1 at count=8;
//      a 5th pair is ignored; drain 6, refill 6 -> pointer wrap, FIFO order preserved.
//   5. count=4, in_valid_0/1=1, issue_ready=1, no hazard -> count stays 4, order preserved.
//   6. count=5, flush=1 with in_valid_0/1=1 -> next cycle count=0, out_valid_0=0.
//   7. Pair 00000033 (add x0,x0,x0) then 00000133 -> no RAW/WAW, out_valid_1=1.

Source files
------------

// File: rtl/dual_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_queue_if
// Description : Fetch-side and issue-side bundle of the dual-issue
//               instruction queue.
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_issue_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
);
    logic                       flush;
    logic                       in_valid_0;
    logic                       in_valid_1;
    logic [XLEN-1:0]            in_pc_0;
    logic [XLEN-1:0]            in_pc_1;
    logic [XLEN-1:0]            in_inst_0;
    logic [XLEN-1:0]            in_inst_1;
    logic                       stall_fetch;
    logic                       issue_ready;
    logic                       out_valid_0;
    logic                       out_valid_1;
    logic [XLEN-1:0]            out_pc_0;
    logic [XLEN-1:0]            out_pc_1;
    logic [XLEN-1:0]            out_inst_0;
    logic [XLEN-1:0]            out_inst_1;
    logic [$clog2(DEPTH):0]     count;

    // Fetch/execute side driving the queue.
    modport master (
        output flush, in_valid_0, in_valid_1, in_pc_0, in_pc_1,
               in_inst_0, in_inst_1, issue_ready,
        input  stall_fetch, out_valid_0, out_valid_1, out_pc_0, out_pc_1,
               out_inst_0, out_inst_1, count
    );

    // The queue itself.
    modport slave (
        input  flush, in_valid_0, in_valid_1, in_pc_0, in_pc_1,
               in_inst_0, in_inst_1, issue_ready,
        output stall_fetch, out_valid_0, out_valid_1, out_pc_0, out_pc_1,
               out_inst_0, out_inst_1, count
    );
endinterface
`default_nettype wire

// File: rtl/dual_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_queue
// Description : Circular instruction buffer between dual fetch and the
//               dual-issue execute stage. Offers the two oldest entries
//               show-ahead and pairs them only when hazard-free.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  wire                 clk,
    input  wire                 rst,
    dual_issue_queue_if.slave   bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [XLEN-1:0] c_NOP = XLEN'(32'h0000_0013);

    logic [XLEN-1:0]    r_pc_mem   [DEPTH];
    logic [XLEN-1:0]    r_inst_mem [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic [c_PTR_W-1:0] w_head_1;
    logic [c_PTR_W-1:0] w_tail_1;
    logic [c_PTR_W-1:0] w_slot1_ptr;
    logic               w_stall;
    logic               w_enq_ok;
    logic [1:0]         w_enq_n;
    logic [1:0]         w_deq_n;
    logic               w_out_v0;
    logic               w_out_v1;
    logic               w_hazard;

    // Opcode classes used by the pairing check.
    function automatic logic f_writes_rd(input logic [XLEN-1:0] inst);
        return (inst[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0110111, 7'b0010111, 7'b1101111,
                                  7'b1100111}) && (inst[11:7] != 5'd0);
    endfunction

    function automatic logic f_reads_rs1(input logic [XLEN-1:0] inst);
        return !(inst[6:0] inside {7'b0110111, 7'b0010111, 7'b1101111});
    endfunction

    function automatic logic f_reads_rs2(input logic [XLEN-1:0] inst);
        return inst[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic f_pair_hazard(input logic [XLEN-1:0] i0,
                                           input logic [XLEN-1:0] i1);
        logic raw, waw, mem, ctrl;
        raw  = f_writes_rd(i0) &&
               ((f_reads_rs1(i1) && (i1[19:15] == i0[11:7])) ||
                (f_reads_rs2(i1) && (i1[24:20] == i0[11:7])));
        waw  = f_writes_rd(i0) && f_writes_rd(i1) && (i0[11:7] == i1[11:7]);
        mem  = (i0[6:0] inside {7'b0000011, 7'b0100011}) &&
               (i1[6:0] inside {7'b0000011, 7'b0100011});
        ctrl = i0[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
        return raw || waw || mem || ctrl;
    endfunction

    assign w_head_1    = r_head + c_PTR_W'(1);
    assign w_tail_1    = r_tail + c_PTR_W'(1);
    assign w_slot1_ptr = bus.in_valid_0 ? w_tail_1 : r_tail;

    // Stall looks only at the registered occupancy, so a pair always fits.
    assign w_stall  = (r_count >= c_CNT_W'(DEPTH - 1));
    assign w_enq_ok = !w_stall && !bus.flush;
    assign w_enq_n  = w_enq_ok ? ({1'b0, bus.in_valid_0} + {1'b0, bus.in_valid_1}) : 2'd0;

    assign w_hazard = f_pair_hazard(r_inst_mem[r_head], r_inst_mem[w_head_1]);
    assign w_out_v0 = (r_count >= c_CNT_W'(1));
    assign w_out_v1 = (r_count >= c_CNT_W'(2)) && !w_hazard;
    assign w_deq_n  = (bus.issue_ready && !bus.flush) ?
                      ({1'b0, w_out_v0} + {1'b0, w_out_v1}) : 2'd0;

    assign bus.stall_fetch = w_stall;
    assign bus.out_valid_0 = w_out_v0;
    assign bus.out_valid_1 = w_out_v1;
    assign bus.out_pc_0    = w_out_v0 ? r_pc_mem[r_head]     : '0;
    assign bus.out_pc_1    = w_out_v1 ? r_pc_mem[w_head_1]   : '0;
    assign bus.out_inst_0  = w_out_v0 ? r_inst_mem[r_head]   : c_NOP;
    assign bus.out_inst_1  = w_out_v1 ? r_inst_mem[w_head_1] : c_NOP;
    assign bus.count       = r_count;

    // Entry storage: slot 0 lands at tail, slot 1 right behind it (or at tail alone).
    always_ff @(posedge clk) begin
        if (w_enq_ok && bus.in_valid_0) begin
            r_pc_mem[r_tail]   <= bus.in_pc_0;
            r_inst_mem[r_tail] <= bus.in_inst_0;
        end
        if (w_enq_ok && bus.in_valid_1) begin
            r_pc_mem[w_slot1_ptr]   <= bus.in_pc_1;
            r_inst_mem[w_slot1_ptr] <= bus.in_inst_1;
        end
    end

    // Pointer and occupancy update; flush empties the queue like reset.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + c_PTR_W'(w_deq_n);
            r_tail  <= r_tail + c_PTR_W'(w_enq_n);
            r_count <= r_count + c_CNT_W'(w_enq_n) - c_CNT_W'(w_deq_n);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dual_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_queue
// Description : Directed self-checking bench for dual_issue_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_queue;
    localparam int c_DEPTH = 8;
    localparam int c_XLEN  = 32;

    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    dual_issue_queue_if #(.XLEN(c_XLEN), .DEPTH(c_DEPTH)) bus ();

    dual_issue_queue #(.DEPTH(c_DEPTH), .XLEN(c_XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // addi x0,x0,k : tagged instruction that never creates a pairing hazard.
    function automatic logic [31:0] mk(input int k);
        return (32'(k) << 20) | 32'h13;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v0, input logic v1,
                        input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] p0, input logic [31:0] p1);
        bus.in_valid_0 = v0;
        bus.in_valid_1 = v1;
        bus.in_inst_0  = i0;
        bus.in_inst_1  = i1;
        bus.in_pc_0    = p0;
        bus.in_pc_1    = p1;
        tick();
        bus.in_valid_0 = 1'b0;
        bus.in_valid_1 = 1'b0;
    endtask

    task automatic push_k(input int k0, input int k1);
        push(1'b1, 1'b1, mk(k0), mk(k1), 32'(k0 * 4), 32'(k1 * 4));
    endtask

    initial begin
        int exp_k [8];
        n_compared   = 0;
        n_mismatched = 0;
        rst             = 1'b1;
        bus.flush       = 1'b0;
        bus.issue_ready = 1'b0;
        bus.in_valid_0  = 1'b0;
        bus.in_valid_1  = 1'b0;
        bus.in_pc_0     = '0;
        bus.in_pc_1     = '0;
        bus.in_inst_0   = '0;
        bus.in_inst_1   = '0;

        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_v0", 32'(bus.out_valid_0), 32'd0);
        check_eq("rst_v1", 32'(bus.out_valid_1), 32'd0);
        check_eq("rst_stall", 32'(bus.stall_fetch), 32'd0);
        check_eq("rst_inst0", bus.out_inst_0, 32'h13);
        check_eq("rst_inst1", bus.out_inst_1, 32'h13);
        check_eq("rst_pc0", bus.out_pc_0, 32'd0);

        // Independent pair, then dual issue.
        push(1'b1, 1'b1, 32'h00500093, 32'h00A00113, 32'd0, 32'd4);
        check_eq("pair_count", 32'(bus.count), 32'd2);
        check_eq("pair_v0", 32'(bus.out_valid_0), 32'd1);
        check_eq("pair_v1", 32'(bus.out_valid_1), 32'd1);
        check_eq("pair_inst0", bus.out_inst_0, 32'h00500093);
        check_eq("pair_pc1", bus.out_pc_1, 32'd4);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check_eq("pair_drain", 32'(bus.count), 32'd0);

        // RAW on x3 forces single issue.
        push(1'b1, 1'b1, 32'h002081B3, 32'h00308333, 32'd8, 32'd12);
        check_eq("raw_v1", 32'(bus.out_valid_1), 32'd0);
        check_eq("raw_count", 32'(bus.count), 32'd2);
        bus.issue_ready = 1'b1;
        tick();
        check_eq("raw_count1", 32'(bus.count), 32'd1);
        check_eq("raw_inst0", bus.out_inst_0, 32'h00308333);
        check_eq("raw_pc0", bus.out_pc_0, 32'd12);
        check_eq("raw_inst1_nop", bus.out_inst_1, 32'h13);
        tick();
        bus.issue_ready = 1'b0;
        check_eq("raw_empty", 32'(bus.count), 32'd0);

        // Fill to full, overflow pair ignored, partial drain, refill across wrap.
        push_k(1, 2);
        push_k(3, 4);
        push_k(5, 6);
        check_eq("fill6_count", 32'(bus.count), 32'd6);
        check_eq("fill6_stall", 32'(bus.stall_fetch), 32'd0);
        push_k(7, 8);
        check_eq("fill8_count", 32'(bus.count), 32'd8);
        check_eq("fill8_stall", 32'(bus.stall_fetch), 32'd1);
        push_k(9, 10);
        check_eq("ovf_count", 32'(bus.count), 32'd8);
        bus.issue_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.issue_ready = 1'b0;
        check_eq("drain6_count", 32'(bus.count), 32'd2);
        check_eq("drain6_inst0", bus.out_inst_0, mk(7));
        check_eq("drain6_stall", 32'(bus.stall_fetch), 32'd0);
        push_k(11, 12);
        push_k(13, 14);
        push_k(15, 16);
        check_eq("refill_count", 32'(bus.count), 32'd8);
        exp_k = '{7, 8, 11, 12, 13, 14, 15, 16};
        bus.issue_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check_eq("wrap_inst0", bus.out_inst_0, mk(exp_k[2*j]));
            check_eq("wrap_inst1", bus.out_inst_1, mk(exp_k[2*j+1]));
            check_eq("wrap_pc0", bus.out_pc_0, 32'(exp_k[2*j] * 4));
            tick();
        end
        bus.issue_ready = 1'b0;
        check_eq("wrap_empty", 32'(bus.count), 32'd0);

        // Simultaneous enqueue and dual dequeue at count 4.
        push_k(21, 22);
        push_k(23, 24);
        bus.issue_ready = 1'b1;
        push_k(25, 26);
        bus.issue_ready = 1'b0;
        check_eq("steady_count", 32'(bus.count), 32'd4);
        check_eq("steady_inst0", bus.out_inst_0, mk(23));
        check_eq("steady_inst1", bus.out_inst_1, mk(24));

        // Lone slot 1 write, then flush with competing enqueue/dequeue.
        push(1'b0, 1'b1, 32'h0, mk(27), 32'h0, 32'd108);
        check_eq("slot1_count", 32'(bus.count), 32'd5);
        bus.flush       = 1'b1;
        bus.issue_ready = 1'b1;
        push_k(28, 29);
        bus.flush       = 1'b0;
        bus.issue_ready = 1'b0;
        check_eq("flush_count", 32'(bus.count), 32'd0);
        check_eq("flush_v0", 32'(bus.out_valid_0), 32'd0);
        check_eq("flush_pc0", bus.out_pc_0, 32'd0);

        // x0 destinations never form a RAW/WAW hazard.
        push(1'b1, 1'b1, 32'h00000033, 32'h00000133, 32'd0, 32'd4);
        check_eq("x0_v1", 32'(bus.out_valid_1), 32'd1);
        check_eq("x0_inst1", bus.out_inst_1, 32'h00000133);

        // Branch first in the pair blocks the partner.
        push(1'b1, 1'b1, 32'h00000063, mk(30), 32'd8, 32'd12);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check_eq("ctrl_inst0", bus.out_inst_0, 32'h00000063);
        check_eq("ctrl_v1", 32'(bus.out_valid_1), 32'd0);

        // Reset mid-operation discards entries.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_count", 32'(bus.count), 32'd0);
        check_eq("midrst_v0", 32'(bus.out_valid_0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
`default_nettype wire
